// File: rtl/alu_issue_scheduler_if.sv
// Handshake bundle for the ALU reservation station: decoder write port, result broadcast snoop
// and the issue port. The slave modport is the scheduler's view; master is the surrounding pipeline.
interface alu_issue_scheduler_if #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 5,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int LOCK_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clear;
  logic              alu_write;
  logic [OP_W-1:0]   in_op;
  logic [LOCK_W-1:0] in_lock1;
  logic [LOCK_W-1:0] in_lock2;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [TAG_W-1:0]  in_dest;
  logic              alu_stall;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              ex_valid;
  logic [OP_W-1:0]   ex_op;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [TAG_W-1:0]  ex_dest;
  logic              ex_ready;
  logic [CNT_W-1:0]  rs_count;

  modport slave (
    input  clear, alu_write, in_op, in_lock1, in_lock2, in_data1, in_data2, in_dest,
           cdb_valid, cdb_tag, cdb_data, ex_ready,
    output alu_stall, ex_valid, ex_op, ex_a, ex_b, ex_dest, rs_count
  );

  modport master (
    output clear, alu_write, in_op, in_lock1, in_lock2, in_data1, in_data2, in_dest,
           cdb_valid, cdb_tag, cdb_data, ex_ready,
    input  alu_stall, ex_valid, ex_op, ex_a, ex_b, ex_dest, rs_count
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: holds ops until both operands resolve, snoops the result bus,
// and issues the oldest ready op each cycle through a single issue register.
module alu_issue_scheduler #(
  parameter int                DEPTH   = 4,
  parameter int                OP_W    = 5,
  parameter int                DATA_W  = 32,
  parameter int                TAG_W   = 4,
  parameter int                LOCK_W  = 5,
  parameter logic [LOCK_W-1:0] NO_LOCK = 5'b10000
) (
  input logic                  clk,
  input logic                  rst,
  alu_issue_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]                    r_vld;
  logic [DEPTH-1:0][OP_W-1:0]          r_op;
  logic [DEPTH-1:0][LOCK_W-1:0]        r_lock1, r_lock2;
  logic [DEPTH-1:0][DATA_W-1:0]        r_data1, r_data2;
  logic [DEPTH-1:0][TAG_W-1:0]         r_dest;
  logic [DEPTH-1:0][DEPTH-1:0]         r_older;
  logic [CNT_W-1:0]                    r_count;
  logic                                r_ex_valid;
  logic [OP_W-1:0]                     r_ex_op;
  logic [DATA_W-1:0]                   r_ex_a, r_ex_b;
  logic [TAG_W-1:0]                    r_ex_dest;

  logic [DEPTH-1:0]  w_rdy, w_sel, w_free, w_alloc_oh;
  logic              w_full, w_alloc, w_take, w_issue;
  logic [OP_W-1:0]   w_iss_op;
  logic [DATA_W-1:0] w_iss_a, w_iss_b;
  logic [TAG_W-1:0]  w_iss_dest;
  logic [LOCK_W-1:0] w_in_l1, w_in_l2;
  logic [DATA_W-1:0] w_in_d1, w_in_d2;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_rdy[i] = r_vld[i] && (r_lock1[i] == NO_LOCK) && (r_lock2[i] == NO_LOCK);
  end

  // Entry i wins when no other ready entry is older than it.
  always_comb begin
    logic blk;
    blk        = 1'b0;
    w_sel      = '0;
    w_iss_op   = '0;
    w_iss_a    = '0;
    w_iss_b    = '0;
    w_iss_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blk = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        blk = blk | (w_rdy[j] & r_older[j][i]);
      w_sel[i] = w_rdy[i] & ~blk;
      if (w_sel[i]) begin
        w_iss_op   = r_op[i];
        w_iss_a    = r_data1[i];
        w_iss_b    = r_data2[i];
        w_iss_dest = r_dest[i];
      end
    end
  end

  // Fullness comes from registered count, so a slot freed this edge is never reused this edge.
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_alloc    = bus.alu_write & ~w_full;
  assign w_take     = ~r_ex_valid | bus.ex_ready;
  assign w_issue    = w_take & (|w_rdy);
  assign w_free     = ~r_vld;
  assign w_alloc_oh = w_free & (~w_free + DEPTH'(1));

  always_comb begin
    w_in_l1 = bus.in_lock1;
    w_in_d1 = bus.in_data1;
    w_in_l2 = bus.in_lock2;
    w_in_d2 = bus.in_data2;
    if (bus.cdb_valid && bus.in_lock1 != NO_LOCK && bus.in_lock1[TAG_W-1:0] == bus.cdb_tag) begin
      w_in_l1 = NO_LOCK;
      w_in_d1 = bus.cdb_data;
    end
    if (bus.cdb_valid && bus.in_lock2 != NO_LOCK && bus.in_lock2[TAG_W-1:0] == bus.cdb_tag) begin
      w_in_l2 = NO_LOCK;
      w_in_d2 = bus.cdb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_op    <= '0;
      r_lock1 <= '0;
      r_lock2 <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_dest  <= '0;
      r_older <= '0;
    end else if (bus.clear) begin
      r_vld   <= '0;
      r_older <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && w_alloc_oh[i]) begin
          r_vld[i]   <= 1'b1;
          r_op[i]    <= bus.in_op;
          r_lock1[i] <= w_in_l1;
          r_data1[i] <= w_in_d1;
          r_lock2[i] <= w_in_l2;
          r_data2[i] <= w_in_d2;
          r_dest[i]  <= bus.in_dest;
          r_older[i] <= '0;
        end else begin
          if (w_issue && w_sel[i])
            r_vld[i] <= 1'b0;
          if (bus.cdb_valid && r_vld[i] && r_lock1[i] != NO_LOCK &&
              r_lock1[i][TAG_W-1:0] == bus.cdb_tag) begin
            r_lock1[i] <= NO_LOCK;
            r_data1[i] <= bus.cdb_data;
          end
          if (bus.cdb_valid && r_vld[i] && r_lock2[i] != NO_LOCK &&
              r_lock2[i][TAG_W-1:0] == bus.cdb_tag) begin
            r_lock2[i] <= NO_LOCK;
            r_data2[i] <= bus.cdb_data;
          end
          if (w_alloc && r_vld[i])
            r_older[i] <= r_older[i] | w_alloc_oh;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_dest  <= '0;
      r_count    <= '0;
    end else if (bus.clear) begin
      r_ex_valid <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_take)
        r_ex_valid <= w_issue;
      if (w_issue) begin
        r_ex_op   <= w_iss_op;
        r_ex_a    <= w_iss_a;
        r_ex_b    <= w_iss_b;
        r_ex_dest <= w_iss_dest;
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_issue);
    end
  end

  assign bus.alu_stall = w_full;
  assign bus.ex_valid  = r_ex_valid;
  assign bus.ex_op     = r_ex_op;
  assign bus.ex_a      = r_ex_a;
  assign bus.ex_b      = r_ex_b;
  assign bus.ex_dest   = r_ex_dest;
  assign bus.rs_count  = r_count;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: a sequence-numbered station model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_issue_scheduler;
  localparam int DEPTH = 4;
  localparam logic [4:0] NL = 5'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_scheduler_if #(.DEPTH(DEPTH)) bus ();
  alu_issue_scheduler #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [4:0]  op;
    logic [4:0]  l1, l2;
    logic [31:0] d1, d2;
    logic [3:0]  dest;
    int          seq;
  } ent_t;

  ent_t        m [DEPTH];
  logic        m_ex_v;
  logic [4:0]  m_ex_op;
  logic [31:0] m_ex_a, m_ex_b;
  logic [3:0]  m_ex_dest;
  int          m_cnt;
  int          seq_ctr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '{1'b0, 5'd0, NL, NL, 32'd0, 32'd0, 4'd0, 0};
    m_ex_v = 1'b0; m_ex_op = '0; m_ex_a = '0; m_ex_b = '0; m_ex_dest = '0;
    m_cnt = 0; seq_ctr = 0;
  endtask

  function automatic logic hit(input logic [4:0] l);
    return bus.cdb_valid && l != NL && l[3:0] == bus.cdb_tag;
  endfunction

  // Oldest = smallest allocation sequence number among fully resolved entries.
  task automatic model_step();
    ent_t n [DEPTH];
    int sel, fr, c;
    if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
      m_ex_v = 1'b0;
    end else begin
      n = m;
      sel = -1; fr = -1; c = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].v) c++;
        if (!m[i].v && fr < 0) fr = i;
        if (m[i].v && m[i].l1 == NL && m[i].l2 == NL && (sel < 0 || m[i].seq < m[sel].seq)) sel = i;
      end
      if (!m_ex_v || bus.ex_ready) begin
        if (sel >= 0) begin
          m_ex_v = 1'b1; m_ex_op = m[sel].op; m_ex_a = m[sel].d1; m_ex_b = m[sel].d2;
          m_ex_dest = m[sel].dest; n[sel].v = 1'b0;
        end else m_ex_v = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) if (m[i].v) begin
        if (hit(m[i].l1)) begin n[i].l1 = NL; n[i].d1 = bus.cdb_data; end
        if (hit(m[i].l2)) begin n[i].l2 = NL; n[i].d2 = bus.cdb_data; end
      end
      if (bus.alu_write && c < DEPTH) begin
        n[fr] = '{1'b1, bus.in_op, bus.in_lock1, bus.in_lock2, bus.in_data1, bus.in_data2,
                  bus.in_dest, seq_ctr};
        if (hit(bus.in_lock1)) begin n[fr].l1 = NL; n[fr].d1 = bus.cdb_data; end
        if (hit(bus.in_lock2)) begin n[fr].l2 = NL; n[fr].d2 = bus.cdb_data; end
        seq_ctr++;
      end
      m = n;
    end
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].v) m_cnt++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ex_valid", bus.ex_valid, m_ex_v);
        chk("rs_count", bus.rs_count, m_cnt);
        chk("alu_stall", bus.alu_stall, m_cnt == DEPTH);
        if (m_ex_v) begin
          chk("ex_op", bus.ex_op, m_ex_op);
          chk("ex_a", bus.ex_a, m_ex_a);
          chk("ex_b", bus.ex_b, m_ex_b);
          chk("ex_dest", bus.ex_dest, m_ex_dest);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] op, input logic [4:0] l1, input logic [31:0] d1,
                    input logic [4:0] l2, input logic [31:0] d2, input logic [3:0] dest);
    bus.alu_write = 1'b1; bus.in_op = op;
    bus.in_lock1 = l1; bus.in_data1 = d1; bus.in_lock2 = l2; bus.in_data2 = d2; bus.in_dest = dest;
    tick();
    bus.alu_write = 1'b0;
  endtask

  task automatic bcast(input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
    tick();
    bus.cdb_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ex_valid"}, bus.ex_valid, 0);
    chk({tag, "_ex_op"}, bus.ex_op, 0);
    chk({tag, "_ex_a"}, bus.ex_a, 0);
    chk({tag, "_ex_b"}, bus.ex_b, 0);
    chk({tag, "_ex_dest"}, bus.ex_dest, 0);
    chk({tag, "_rs_count"}, bus.rs_count, 0);
    chk({tag, "_alu_stall"}, bus.alu_stall, 0);
  endtask

  initial begin
    bus.clear = 0; bus.alu_write = 0; bus.in_op = 0; bus.in_lock1 = NL; bus.in_lock2 = NL;
    bus.in_data1 = 0; bus.in_data2 = 0; bus.in_dest = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0; bus.ex_ready = 1;
    #3 chk_reset_outputs("init");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Ready op: issue visible after the second edge, station empty by then.
    wr(5'd1, NL, 32'd5, NL, 32'd7, 4'd3);
    tick();
    chk("ready_valid", bus.ex_valid, 1);
    chk("ready_a", bus.ex_a, 5);
    chk("ready_b", bus.ex_b, 7);
    chk("ready_dest", bus.ex_dest, 3);
    tick();
    chk("ready_cnt", bus.rs_count, 0);

    // Capture: waits until the broadcast resolves lock1.
    wr(5'd2, 5'd2, 32'd0, NL, 32'd9, 4'd5);
    repeat (3) tick();
    chk("cap_wait", bus.ex_valid, 0);
    bcast(4'd2, 32'h100);
    chk("cap_not_same_edge", bus.ex_valid, 0);
    tick();
    chk("cap_a", bus.ex_a, 32'h100);
    chk("cap_b", bus.ex_b, 9);
    chk("cap_dest", bus.ex_dest, 5);
    tick();

    // Oldest first: B, C ready bypass waiting A.
    wr(5'd3, 5'd1, 32'd0, NL, 32'd1, 4'd1);
    wr(5'd3, NL, 32'd2, NL, 32'd2, 4'd2);
    wr(5'd3, NL, 32'd3, NL, 32'd3, 4'd3);
    chk("age_b", bus.ex_dest, 2);
    tick();
    chk("age_c", bus.ex_dest, 3);
    bcast(4'd1, 32'h55);
    tick();
    chk("age_a_dest", bus.ex_dest, 1);
    chk("age_a_val", bus.ex_a, 32'h55);
    // D lands in a lower index than A2 but is younger.
    wr(5'd4, NL, 32'd8, NL, 32'd8, 4'd8);
    wr(5'd4, 5'd6, 32'd0, NL, 32'd1, 4'd9);
    wr(5'd4, NL, 32'd2, 5'd6, 32'd0, 4'd10);
    bcast(4'd6, 32'h66);
    tick();
    chk("age_a2_first", bus.ex_dest, 9);
    chk("age_a2_a", bus.ex_a, 32'h66);
    tick();
    chk("age_d_second", bus.ex_dest, 10);
    chk("age_d_b", bus.ex_b, 32'h66);
    tick();

    // Full and stall.
    bus.ex_ready = 0;
    for (int k = 1; k <= 4; k++) wr(5'd5, 5'd7, 32'd0, NL, 32'(k), 4'(k));
    chk("full_stall", bus.alu_stall, 1);
    chk("full_cnt", bus.rs_count, 4);
    wr(5'd5, NL, 32'd1, NL, 32'd1, 4'd15);
    chk("full_drop_cnt", bus.rs_count, 4);
    bcast(4'd7, 32'h77);
    tick();
    chk("full_after_issue_cnt", bus.rs_count, 3);
    chk("full_after_issue_stall", bus.alu_stall, 0);
    chk("full_first_dest", bus.ex_dest, 1);

    // Backpressure hold, then clear beats a simultaneous write.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_dest", bus.ex_dest, 1);
      chk("hold_a", bus.ex_a, 32'h77);
      chk("hold_b", bus.ex_b, 1);
    end
    bus.clear = 1'b1;
    wr(5'd6, NL, 32'd4, NL, 32'd4, 4'd14);
    bus.clear = 1'b0;
    chk("clr_valid", bus.ex_valid, 0);
    chk("clr_cnt", bus.rs_count, 0);
    tick();
    chk("clr_discard_valid", bus.ex_valid, 0);
    chk("clr_discard_cnt", bus.rs_count, 0);

    // Mid-cycle reset with occupied entries and a held issue.
    wr(5'd7, NL, 32'd6, NL, 32'd6, 4'd6);
    tick();
    for (int k = 0; k < 3; k++) wr(5'd7, 5'd3, 32'd0, NL, 32'd0, 4'(k));
    chk("pre_rst_cnt", bus.rs_count, 3);
    chk("pre_rst_valid", bus.ex_valid, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    @(posedge clk); #1 rst = 1'b0;
    bus.ex_ready = 1;
    wr(5'd8, NL, 32'd11, NL, 32'd12, 4'd13);
    tick();
    chk("post_rst_dest", bus.ex_dest, 13);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
